// File: rtl/ddr3_arb_pkg.sv
// Shared types and default widths for the DDR3 CPU port arbiter.
// Request entries are packed {cmd, ba, addr, col, wr_data}.
package ddr3_arb_pkg;

  localparam int DEF_BA_W   = 3;
  localparam int DEF_ROW_W  = 15;
  localparam int DEF_COL_W  = 10;
  localparam int DEF_DATA_W = 64;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  typedef struct packed {
    cmd_e                  cmd;
    logic [DEF_BA_W-1:0]   ba;
    logic [DEF_ROW_W-1:0]  addr;
    logic [DEF_COL_W-1:0]  col;
    logic [DEF_DATA_W-1:0] wr_data;
  } req_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr3_req_fifo.sv
// Synchronous FIFO with full/empty/count; push is refused while full.
// DEPTH must be a power of two so the pointers wrap naturally.
module ddr3_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ddr3_cpu_port_arbiter.sv
// Multi-port CPU front end: per-port request FIFOs, round-robin
// arbitration into one registered request, in-order read-tag return.
module ddr3_cpu_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RD_OUT = 8,
  parameter int BA_W       = DEF_BA_W,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int COL_W      = DEF_COL_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                          CPU_CLK,
  input  logic                          RESET,
  input  logic [NUM_PORTS-1:0]          P_VALID,
  output logic [NUM_PORTS-1:0]          P_READY,
  input  logic [NUM_PORTS-1:0]          P_CMD,
  input  logic [NUM_PORTS*BA_W-1:0]     P_BA,
  input  logic [NUM_PORTS*ROW_W-1:0]    P_ADDR,
  input  logic [NUM_PORTS*COL_W-1:0]    P_COL,
  input  logic [NUM_PORTS*DATA_W-1:0]   P_WR_DATA,
  output logic [NUM_PORTS-1:0]          P_RD_VALID,
  output logic [DATA_W-1:0]             P_RD_DATA,
  output logic                          REQ_VALID,
  input  logic                          REQ_READY,
  output logic                          REQ_CMD,
  output logic [BA_W-1:0]               REQ_BA,
  output logic [ROW_W-1:0]              REQ_ADDR,
  output logic [COL_W-1:0]              REQ_COL,
  output logic [DATA_W-1:0]             REQ_WR_DATA,
  output logic [id_w(NUM_PORTS)-1:0]    REQ_PORT,
  input  logic                          CONT_RD_VALID,
  input  logic [DATA_W-1:0]             CONT_RD_DATA,
  output logic                          RD_ERR
);

  localparam int PW  = id_w(NUM_PORTS);
  localparam int EW  = 1 + BA_W + ROW_W + COL_W + DATA_W;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int TCW = $clog2(MAX_RD_OUT) + 1;

  logic [EW-1:0]        head [NUM_PORTS];
  logic [FCW-1:0]       unused_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] f_full;
  logic [NUM_PORTS-1:0] f_empty;
  logic [NUM_PORTS-1:0] f_push;
  logic [NUM_PORTS-1:0] f_pop;
  logic [NUM_PORTS-1:0] elig;

  logic                 t_full;
  logic                 t_empty;
  logic                 t_push;
  logic [PW-1:0]        t_head;
  logic [TCW-1:0]       unused_tcnt;

  logic                 load;
  logic                 gnt_found;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        rr_ptr;
  logic [EW-1:0]        gnt_head;
  logic                 gnt_rd;

  assign P_READY = ~f_full & {NUM_PORTS{~RESET}};
  assign f_push  = P_VALID & P_READY;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    ddr3_req_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (CPU_CLK),
      .rst   (RESET),
      .push  (f_push[i]),
      .din   ({P_CMD[i],
               P_BA[i*BA_W +: BA_W],
               P_ADDR[i*ROW_W +: ROW_W],
               P_COL[i*COL_W +: COL_W],
               P_WR_DATA[i*DATA_W +: DATA_W]}),
      .pop   (f_pop[i]),
      .dout  (head[i]),
      .full  (f_full[i]),
      .empty (f_empty[i]),
      .count (unused_cnt[i])
    );

    // a read head with no free tag stalls its whole port
    assign elig[i] = ~f_empty[i] &
      ((cmd_e'(head[i][EW-1]) == CMD_WR) | ~t_full);
  end

  assign load = ~REQ_VALID | REQ_READY;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!gnt_found &&
          elig[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'((int'(rr_ptr) + k) % NUM_PORTS);
      end
    end
  end

  assign gnt_head = head[gnt_idx];
  assign gnt_rd   = (cmd_e'(gnt_head[EW-1]) == CMD_RD);
  assign t_push   = load & gnt_found & gnt_rd;

  always_comb begin
    f_pop = '0;
    if (load && gnt_found)
      f_pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge CPU_CLK) begin
    if (RESET) begin
      REQ_VALID   <= 1'b0;
      REQ_CMD     <= 1'b0;
      REQ_BA      <= '0;
      REQ_ADDR    <= '0;
      REQ_COL     <= '0;
      REQ_WR_DATA <= '0;
      REQ_PORT    <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      REQ_VALID <= gnt_found;
      if (gnt_found) begin
        {REQ_CMD, REQ_BA, REQ_ADDR,
         REQ_COL, REQ_WR_DATA} <= gnt_head;
        REQ_PORT <= gnt_idx;
        rr_ptr   <= (gnt_idx == PW'(NUM_PORTS - 1))
                    ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  ddr3_req_fifo #(
    .WIDTH (PW),
    .DEPTH (MAX_RD_OUT)
  ) u_tag (
    .clk   (CPU_CLK),
    .rst   (RESET),
    .push  (t_push),
    .din   (gnt_idx),
    .pop   (CONT_RD_VALID),
    .dout  (t_head),
    .full  (t_full),
    .empty (t_empty),
    .count (unused_tcnt)
  );

  always_ff @(posedge CPU_CLK) begin
    if (RESET) begin
      P_RD_VALID <= '0;
      P_RD_DATA  <= '0;
      RD_ERR     <= 1'b0;
    end else begin
      P_RD_VALID <= '0;
      if (CONT_RD_VALID) begin
        if (t_empty) begin
          RD_ERR <= 1'b1;
        end else begin
          P_RD_VALID[t_head] <= 1'b1;
          P_RD_DATA          <= CONT_RD_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr3_cpu_port_arbiter.sv
// Bench for ddr3_cpu_port_arbiter: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_ddr3_cpu_port_arbiter;
  import ddr3_arb_pkg::*;

  localparam int N  = 2;
  localparam int FD = 4;
  localparam int MR = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   pv;
  logic [1:0]   p_ready;
  logic [1:0]   pcmd;
  logic [5:0]   pba;
  logic [29:0]  paddr;
  logic [19:0]  pcol;
  logic [127:0] pwd;
  logic [1:0]   p_rd_valid;
  logic [63:0]  p_rd_data;
  logic         req_valid;
  logic         req_ready;
  logic         req_cmd;
  logic [2:0]   req_ba;
  logic [14:0]  req_addr;
  logic [9:0]   req_col;
  logic [63:0]  req_wr_data;
  logic [0:0]   req_port;
  logic         cont_rv;
  logic [63:0]  cont_rd;
  logic         rd_err;

  always #5 clk = ~clk;

  ddr3_cpu_port_arbiter dut (
    .CPU_CLK       (clk),
    .RESET         (rst),
    .P_VALID       (pv),
    .P_READY       (p_ready),
    .P_CMD         (pcmd),
    .P_BA          (pba),
    .P_ADDR        (paddr),
    .P_COL         (pcol),
    .P_WR_DATA     (pwd),
    .P_RD_VALID    (p_rd_valid),
    .P_RD_DATA     (p_rd_data),
    .REQ_VALID     (req_valid),
    .REQ_READY     (req_ready),
    .REQ_CMD       (req_cmd),
    .REQ_BA        (req_ba),
    .REQ_ADDR      (req_addr),
    .REQ_COL       (req_col),
    .REQ_WR_DATA   (req_wr_data),
    .REQ_PORT      (req_port),
    .CONT_RD_VALID (cont_rv),
    .CONT_RD_DATA  (cont_rd),
    .RD_ERR        (rd_err)
  );

  int checks = 0;
  int errors = 0;

  // reference model: queues of whole requests and of tag port ids
  req_t        mq [N][$];
  int          mtags [$];
  bit          m_ov;
  req_t        m_out;
  int          m_port;
  int          m_rr;
  bit [1:0]    m_rdv;
  logic [63:0] m_rdd;
  bit          m_err;

  typedef struct {
    logic [1:0] pv;
    logic       rr;
    logic       exp_rv;
    logic       exp_port;
    logic [1:0] exp_rdy;
  } vec_t;

  vec_t tv [21];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic req_t port_entry(input int i);
    req_t e;
    e.cmd     = cmd_e'(pcmd[i]);
    e.ba      = pba[i*3 +: 3];
    e.addr    = paddr[i*15 +: 15];
    e.col     = pcol[i*10 +: 10];
    e.wr_data = pwd[i*64 +: 64];
    return e;
  endfunction

  task automatic model_edge();
    int  tpre;
    int  p;
    int  t;
    bit  found;
    bit [1:0] rdy;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      mtags.delete();
      m_ov = 0; m_out = '0; m_port = 0; m_rr = 0;
      m_rdv = '0; m_rdd = '0; m_err = 0;
      return;
    end
    tpre = mtags.size();
    for (int i = 0; i < N; i++)
      rdy[i] = (mq[i].size() < FD);
    m_rdv = '0;
    if (cont_rv) begin
      if (mtags.size() > 0) begin
        t = mtags.pop_front();
        m_rdv[t] = 1'b1;
        m_rdd = cont_rd;
      end else begin
        m_err = 1'b1;
      end
    end
    if (!m_ov || req_ready) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        p = (m_rr + k) % N;
        if (!found && mq[p].size() > 0 &&
            (mq[p][0].cmd == CMD_WR || tpre < MR)) begin
          found  = 1;
          m_out  = mq[p].pop_front();
          m_port = p;
          m_rr   = (p + 1) % N;
          if (m_out.cmd == CMD_RD) mtags.push_back(p);
        end
      end
      m_ov = found;
    end
    for (int i = 0; i < N; i++)
      if (pv[i] && rdy[i]) mq[i].push_back(port_entry(i));
  endtask

  task automatic compare_model();
    logic [1:0] er;
    er[0] = !rst && (mq[0].size() < FD);
    er[1] = !rst && (mq[1].size() < FD);
    chk("m_p_ready", 128'(p_ready), 128'(er));
    chk("m_req_valid", 128'(req_valid), 128'(m_ov));
    if (m_ov)
      chk("m_req_fields",
          128'({req_cmd, req_ba, req_addr, req_col,
                req_wr_data, req_port}),
          128'({m_out, m_port[0]}));
    chk("m_p_rd_valid", 128'(p_rd_valid), 128'(m_rdv));
    chk("m_p_rd_data", 128'(p_rd_data), 128'(m_rdd));
    chk("m_rd_err", 128'(rd_err), 128'(m_err));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic rand_fields();
    pba   = 6'($urandom);
    paddr = 30'($urandom);
    pcol  = 20'($urandom);
    pwd   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle();
    pv      = '0;
    cont_rv = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pv = '0; pcmd = '0; pba = '0;
    paddr = '0; pcol = '0; pwd = '0;
    req_ready = 1'b1; cont_rv = 1'b0; cont_rd = '0;

    cycle();
    cycle();
    chk("reset_outs",
        128'({p_ready, req_valid, p_rd_valid, rd_err,
              req_cmd, req_port, req_ba, req_addr, req_col}),
        128'(0));
    chk("reset_data", 128'({req_wr_data, p_rd_data}), 128'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 128'(p_ready), 128'(2'b11));

    tv[0]  = '{2'b11, 1, 0, 0, 2'b11};
    tv[1]  = '{2'b11, 1, 1, 0, 2'b11};
    tv[2]  = '{2'b11, 1, 1, 1, 2'b11};
    tv[3]  = '{2'b11, 1, 1, 0, 2'b11};
    tv[4]  = '{2'b00, 1, 1, 1, 2'b11};
    tv[5]  = '{2'b00, 1, 1, 0, 2'b11};
    tv[6]  = '{2'b00, 1, 1, 1, 2'b11};
    tv[7]  = '{2'b00, 1, 1, 0, 2'b11};
    tv[8]  = '{2'b00, 1, 1, 1, 2'b11};
    tv[9]  = '{2'b00, 1, 0, 0, 2'b11};
    tv[10] = '{2'b10, 0, 0, 0, 2'b11};
    tv[11] = '{2'b10, 0, 1, 1, 2'b11};
    tv[12] = '{2'b10, 0, 1, 1, 2'b11};
    tv[13] = '{2'b10, 0, 1, 1, 2'b11};
    tv[14] = '{2'b10, 0, 1, 1, 2'b01};
    tv[15] = '{2'b00, 0, 1, 1, 2'b01};
    tv[16] = '{2'b00, 1, 1, 1, 2'b11};
    tv[17] = '{2'b00, 1, 1, 1, 2'b11};
    tv[18] = '{2'b00, 1, 1, 1, 2'b11};
    tv[19] = '{2'b00, 1, 1, 1, 2'b11};
    tv[20] = '{2'b00, 1, 0, 0, 2'b11};

    pcmd = 2'b11;
    for (int i = 0; i < 21; i++) begin
      pv = tv[i].pv;
      req_ready = tv[i].rr;
      rand_fields();
      cycle();
      chk($sformatf("tv%0d_valid", i),
          128'(req_valid), 128'(tv[i].exp_rv));
      if (tv[i].exp_rv)
        chk($sformatf("tv%0d_port", i),
            128'(req_port), 128'(tv[i].exp_port));
      chk($sformatf("tv%0d_ready", i),
          128'(p_ready), 128'(tv[i].exp_rdy));
    end

    // single write with fixed fields
    req_ready = 1'b1;
    pv = 2'b01; pcmd = 2'b01;
    pba = 6'd2; paddr = 30'h1A5; pcol = 20'h3F;
    pwd = {64'h0, 64'hDEADBEEF_CAFEF00D};
    cycle();
    chk("sw_pre", 128'(req_valid), 128'(0));
    idle();
    cycle();
    chk("sw_valid", 128'(req_valid), 128'(1));
    chk("sw_fields",
        128'({req_cmd, req_ba, req_addr, req_col,
              req_wr_data, req_port}),
        128'({1'b1, 3'd2, 15'h1A5, 10'h3F,
              64'hDEADBEEF_CAFEF00D, 1'b0}));
    cycle();
    chk("sw_drop", 128'(req_valid), 128'(0));

    // tag FIFO full: port 0 read stalls, port 1 write passes
    pcmd = 2'b00;
    for (int i = 0; i < MR; i++) begin
      pv = 2'b01;
      rand_fields();
      cycle();
    end
    pv = 2'b11; pcmd = 2'b10;
    cycle();
    idle();
    cycle();
    chk("tf_wr_grant",
        128'({req_valid, req_port, req_cmd}), 128'(3'b111));
    cycle();
    chk("tf_rd_held", 128'(req_valid), 128'(0));
    cont_rv = 1'b1; cont_rd = 64'h0123_4567_89AB_CDEF;
    cycle();
    cont_rv = 1'b0;
    chk("tf_strobe",
        128'({p_rd_valid, p_rd_data, req_valid}),
        128'({2'b01, 64'h0123_4567_89AB_CDEF, 1'b0}));
    cycle();
    chk("tf_rd_issue",
        128'({req_valid, req_port, req_cmd}), 128'(3'b100));

    // reset with queued work, then an untagged return
    req_ready = 1'b0; pcmd = 2'b11;
    for (int i = 0; i < 3; i++) begin
      pv = 2'b01;
      rand_fields();
      cycle();
    end
    do_reset();
    cont_rv = 1'b1; cont_rd = 64'h55;
    cycle();
    cont_rv = 1'b0;
    chk("rst_outs",
        128'({req_valid, p_rd_valid, rd_err, p_ready}),
        128'({1'b0, 2'b00, 1'b1, 2'b11}));
    cycle();
    chk("rst_err_sticky", 128'(rd_err), 128'(1));

    // in-order read return to ports 1, 0, 1
    do_reset();
    req_ready = 1'b1; pcmd = 2'b00;
    pv = 2'b10; rand_fields(); cycle();
    pv = 2'b01; rand_fields(); cycle();
    pv = 2'b10; rand_fields(); cycle();
    idle();
    cycle();
    cycle();
    cont_rv = 1'b1; cont_rd = 64'h11;
    cycle();
    chk("rr_ret0", 128'({p_rd_valid, p_rd_data}),
        128'({2'b10, 64'h11}));
    cont_rd = 64'h22;
    cycle();
    chk("rr_ret1", 128'({p_rd_valid, p_rd_data}),
        128'({2'b01, 64'h22}));
    cont_rd = 64'h33;
    cycle();
    chk("rr_ret2", 128'({p_rd_valid, p_rd_data}),
        128'({2'b10, 64'h33}));
    cont_rv = 1'b0;
    cycle();
    chk("rr_quiet", 128'({p_rd_valid, rd_err}), 128'(0));

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      pv        = 2'($urandom);
      pcmd      = 2'($urandom);
      req_ready = ($urandom % 4) != 0;
      cont_rv   = (mtags.size() > 0) ? ($urandom % 3 == 0)
                                     : ($urandom % 60 == 0);
      cont_rd   = {$urandom, $urandom};
      rst       = ($urandom % 400 == 0);
      rand_fields();
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
